// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        re_i;
  logic        we_i;
  logic [63:0] addr_i;
  logic [7:0]  wmask_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        finish_o;
  logic        err_o;

  modport master (
    output re_i, we_i, addr_i, wmask_i, wdata_i,
    input  rdata_o, finish_o, err_o
  );

  modport slave (
    input  re_i, we_i, addr_i, wmask_i, wdata_i,
    output rdata_o, finish_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a held MEM-stage request, waits LATENCY cycles,
// then pulses finish with read data / error and commits byte-masked writes.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [63:0] cap_addr;
  logic [7:0]  cap_mask;
  logic [63:0] cap_wdata;
  logic [63:0] rdata_q;
  logic        finish_q;
  logic        err_q;

  logic [63:0] ram [DEPTH_WORDS];

  logic [63:0]      req_addr;
  logic [63:0]      off;
  logic             req_we;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0]      resp_data;

  // In IDLE the live bus is decoded so a zero-latency request can respond on the next edge;
  // everywhere else only the captured request is used.
  always_comb begin
    req_addr  = (state == IDLE) ? bus.addr_i : cap_addr;
    req_we    = (state == IDLE) ? bus.we_i   : cap_we;
    off       = req_addr - BASE_ADDR;
    in_range  = (off < SPAN);
    idx       = off[IDX_W+2:3];
    resp_data = (req_we || !in_range) ? '0 : ram[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_mask  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      case (state)
        IDLE: begin
          if (bus.re_i || bus.we_i) begin
            cap_we    <= bus.we_i;
            cap_addr  <= bus.addr_i;
            cap_mask  <= bus.wmask_i;
            cap_wdata <= bus.wdata_i;
            cnt       <= LAT;
            if (LAT == 4'd0) begin
              state    <= RESP;
              finish_q <= 1'b1;
              err_q    <= !in_range;
              rdata_q  <= resp_data;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESP;
            finish_q <= 1'b1;
            err_q    <= !in_range;
            rdata_q  <= resp_data;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit happens on the edge leaving RESP; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == RESP && cap_we && in_range) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (cap_mask[b]) ram[idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.finish_o = finish_q;
  assign bus.err_o    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 default build and a LATENCY=0 small build,
// checked against a word-level memory model.
module tb_dmem_responder;
  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam int          LAT_A   = 2;
  localparam int          LAT_B   = 0;
  localparam longint      DEPTH_A = 4096;
  localparam longint      DEPTH_B = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if ia ();
  dmem_responder_if ib ();

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] mem_a [longint];
  logic [63:0] mem_b [longint];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit re, input bit we, input logic [63:0] addr,
                       input logic [7:0] mask, input logic [63:0] wd);
    if (sel) begin
      ib.re_i = re; ib.we_i = we; ib.addr_i = addr; ib.wmask_i = mask; ib.wdata_i = wd;
    end else begin
      ia.re_i = re; ia.we_i = we; ia.addr_i = addr; ia.wmask_i = mask; ia.wdata_i = wd;
    end
  endtask

  task automatic sample(input bit sel, output logic fin, output logic [63:0] rd, output logic er);
    if (sel) begin fin = ib.finish_o; rd = ib.rdata_o; er = ib.err_o; end
    else     begin fin = ia.finish_o; rd = ia.rdata_o; er = ia.err_o; end
  endtask

  function automatic logic [63:0] model_rd(input bit sel, input longint w);
    if (sel) return mem_b.exists(w) ? mem_b[w] : 64'h0;
    return mem_a.exists(w) ? mem_a[w] : 64'h0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full request: issue, wait (bounded) for finish, compare, release, confirm single pulse.
  task automatic do_req(input bit sel, input bit re, input bit we, input logic [63:0] addr,
                        input logic [7:0] mask, input logic [63:0] wd, input string tag);
    int n;
    logic fin, er, exp_er;
    logic [63:0] rd, exp_rd, off, old, bm;
    longint depth, w;
    int lat;
    depth  = sel ? DEPTH_B : DEPTH_A;
    lat    = sel ? LAT_B : LAT_A;
    off    = addr - BASE;
    w      = longint'(off >> 3);
    exp_er = !(off < 64'(depth) * 64'd8);
    exp_rd = (we || exp_er) ? 64'h0 : model_rd(sel, w);
    drive(sel, re, we, addr, mask, wd);
    sample(sel, fin, rd, er);
    check({tag, ".idle_fin"}, 64'(fin), 64'h0);
    n = 0;
    fin = 1'b0;
    while (!fin && n < 40) begin
      tick();
      n++;
      sample(sel, fin, rd, er);
    end
    check({tag, ".latency"}, 64'(n), 64'(lat + 1));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 64'(er), 64'(exp_er));
    if (we && !exp_er) begin
      old = model_rd(sel, w);
      bm  = '0;
      for (int i = 0; i < 8; i++) if (mask[i]) bm = bm | (64'hFF << (8 * i));
      if (sel) mem_b[w] = (old & ~bm) | (wd & bm);
      else     mem_a[w] = (old & ~bm) | (wd & bm);
    end
    drive(sel, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
    tick();
    sample(sel, fin, rd, er);
    check({tag, ".one_pulse"}, 64'(fin), 64'h0);
  endtask

  initial begin
    logic fin, er;
    logic [63:0] rd, exp_rd;
    int n, pulses;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);

    // Reset held with a live read request: outputs stay quiet.
    ia.re_i = 1'b1;
    ib.re_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample(1'b0, fin, rd, er);
      check("rst.fin", 64'(fin), 64'h0);
      check("rst.rdata", rd, 64'h0);
      check("rst.err", 64'(er), 64'h0);
      sample(1'b1, fin, rd, er);
      check("rst.fin_b", 64'(fin), 64'h0);
    end
    ib.re_i = 1'b0;
    rst = 1'b1;
    do_req(1'b0, 1'b1, 1'b0, 64'h0, 8'h0, 64'h0, "rst_release");

    // Full write / read / byte-masked write / zero-mask write.
    do_req(1'b0, 1'b0, 1'b1, 64'h8000_0008, 8'hFF, 64'h1122334455667788, "wr_full");
    do_req(1'b0, 1'b1, 1'b0, 64'h8000_0008, 8'h00, 64'h0, "rd_full");
    check("rd_full.const", model_rd(1'b0, 1), 64'h1122334455667788);
    do_req(1'b0, 1'b0, 1'b1, 64'h8000_000A, 8'h04, 64'h0000_0000_00AB_0000, "wr_byte");
    do_req(1'b0, 1'b1, 1'b0, 64'h8000_0008, 8'h00, 64'h0, "rd_byte");
    do_req(1'b0, 1'b0, 1'b1, 64'h8000_0008, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "wr_nomask");
    do_req(1'b0, 1'b1, 1'b1, 64'h8000_0008, 8'h00, 64'h0, "both_is_write");
    do_req(1'b0, 1'b1, 1'b0, 64'h8000_0008, 8'h00, 64'h0, "rd_nomask");

    // Out of range on both sides of the window.
    do_req(1'b0, 1'b1, 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, "oor_rd_low");
    do_req(1'b0, 1'b0, 1'b1, BASE + 64'(DEPTH_A - 1) * 8, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, "wr_last");
    do_req(1'b0, 1'b0, 1'b1, BASE + 64'(DEPTH_A) * 8, 8'hFF, 64'h0123_4567_89AB_CDEF, "oor_wr_high");
    do_req(1'b0, 1'b1, 1'b0, BASE + 64'(DEPTH_A - 1) * 8, 8'h00, 64'h0, "rd_last");

    // Seed words 0..7 of both memories so random reads have defined contents.
    for (int w = 0; w < 8; w++) begin
      do_req(1'b0, 1'b0, 1'b1, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom}, "seed_a");
      do_req(1'b1, 1'b0, 1'b1, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom}, "seed_b");
    end

    // Address changes while BUSY must not affect the response.
    exp_rd = model_rd(1'b0, 2);
    drive(1'b0, 1'b1, 1'b0, BASE + 64'd16, 8'h0, 64'h0);
    tick();
    ia.addr_i = BASE + 64'd24;
    n = 1;
    sample(1'b0, fin, rd, er);
    while (!fin && n < 40) begin tick(); n++; sample(1'b0, fin, rd, er); end
    check("busy_addr.latency", 64'(n), 64'(LAT_A + 1));
    check("busy_addr.rdata", rd, exp_rd);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
    tick();

    // LATENCY=0: a held read yields pulses at T+1 and T+3, never adjacent.
    exp_rd = model_rd(1'b1, 1);
    drive(1'b1, 1'b1, 1'b0, BASE + 64'd8, 8'h0, 64'h0);
    tick(); sample(1'b1, fin, rd, er);
    check("b2b.fin1", 64'(fin), 64'h1);
    check("b2b.rd1", rd, exp_rd);
    tick(); sample(1'b1, fin, rd, er);
    check("b2b.gap", 64'(fin), 64'h0);
    tick(); sample(1'b1, fin, rd, er);
    check("b2b.fin2", 64'(fin), 64'h1);
    check("b2b.rd2", rd, exp_rd);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
    tick(); sample(1'b1, fin, rd, er);
    check("b2b.end", 64'(fin), 64'h0);

    // Randomized mix on both builds.
    for (int it = 0; it < 80; it++) begin
      bit sel, we;
      int kind;
      logic [63:0] addr;
      longint depth;
      sel   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 5);
      depth = sel ? DEPTH_B : DEPTH_A;
      if (kind < 4)       addr = BASE + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      else if (kind == 4) addr = BASE - 64'($urandom_range(1, 64));
      else                addr = BASE + 64'(depth) * 8 + 64'($urandom_range(0, 255));
      do_req(sel, !we, we, addr, 8'($urandom), {$urandom, $urandom}, sel ? "rand_b" : "rand_a");
    end

    // Reset during BUSY aborts the write with no pulse; the old word survives.
    drive(1'b0, 1'b0, 1'b1, BASE + 64'd8, 8'hFF, 64'h0000_0000_0000_DEAD);
    tick();
    rst = 1'b0;
    #1;
    sample(1'b0, fin, rd, er);
    check("abort.fin_rst", 64'(fin), 64'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sample(1'b0, fin, rd, er);
      if (fin) pulses++;
    end
    check("abort.no_pulse", 64'(pulses), 64'h0);
    do_req(1'b0, 1'b1, 1'b0, BASE + 64'd8, 8'h00, 64'h0, "abort_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the MEM-stage load/store interface.
- Accepts the stage's held read/write request (address, byte mask, write data) and runs a configurable number of wait states.
- Commits byte-masked writes into an internal 64-bit-wide RAM.
- Returns read data together with a one-cycle finish pulse, which releases the MEM-stage stall.

Parameters:
- DEPTH_WORDS, 4096, number of 64-bit words in the internal RAM (power of two).
- LATENCY, 2, wait-state cycles between request capture and the finish pulse (0..15).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- re_i  in  1  read request, held high by the initiator until finish_o.
- we_i  in  1  write request, held high by the initiator until finish_o.
- addr_i  in  64  byte address; bits [2:0] ignored (lane placement is done by the initiator).
- wmask_i  in  8  byte-lane write enables, bit n covers wdata_i[8n+7:8n].
- wdata_i  in  64  lane-aligned write data.
- rdata_o  out  64  full 64-bit word read; valid only while finish_o=1.
- finish_o  out  1  one-cycle completion pulse.
- err_o  out  1  out-of-range flag; valid only while finish_o=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, finish_o=0, err_o=0, rdata_o=0.
  - Captured request registers are cleared; a pending write is discarded.
  - RAM contents are not reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Transitions only if (re_i|we_i)=1.
  - Captures addr_i, wmask_i, wdata_i and op. Op is write if we_i=1, otherwise read; write has priority if both are high.
  - Loads the wait counter with LATENCY.
  - Next state is BUSY if LATENCY>0, else RESP.
- BUSY:
  - Counter decrements each cycle.
  - Moves to RESP on the edge where the counter reaches 0.
  - Input changes during BUSY are ignored; only captured values are used.
- RESP (exactly one cycle):
  - finish_o=1.
  - For a read, rdata_o = RAM word read at the captured index; for a write, rdata_o=0.
  - err_o=1 if the captured address is out of range.
  - Next state is always IDLE.
- Latency: a request first seen in IDLE at cycle T produces finish_o at cycle T+LATENCY+1.
  - Back-to-back requests: finish pulses are separated by at least LATENCY+2 cycles.
  - A request still high in the IDLE cycle after RESP is treated as a new request.
- Address decode:
  - off = captured addr - BASE_ADDR (64-bit unsigned subtraction, wraps).
  - In range iff off < DEPTH_WORDS*8. Index = off[log2(DEPTH_WORDS)+2:3].
- Write commit:
  - Occurs on the clock edge ending the RESP cycle, only if in range.
  - Only bytes whose wmask bit is 1 are updated.
  - wmask=0 completes normally with no RAM change.
- Out of range:
  - Read returns rdata_o=0 with err_o=1.
  - Write is dropped with err_o=1.
  - finish_o is still asserted, so the initiator never deadlocks.
- Read data is sampled from RAM at the RESP cycle, after any earlier writes have committed, so read-after-write returns the new data.
- Reset in BUSY or RESP: immediate return to IDLE, no finish_o pulse, no RAM write.
- The initiator's stall is (re|we)&~finish_o, so finish_o must never be asserted in IDLE or BUSY.

Test Plan:
1. Reset: hold rst=0 with re_i=1 -> finish_o=0, rdata_o=0, err_o=0. Release rst; with re_i held high at T, finish_o=1 at T+3 (LATENCY=2) and low at T+2 and T+4.
2. Full write then read: we_i=1, addr 0x8000_0008, wmask 0xFF, wdata 0x1122334455667788 -> finish_o one cycle at T+3, err_o=0. Then re_i at the same address -> rdata_o=0x1122334455667788 during finish_o.
3. Byte-masked write: after test 2, write addr 0x8000_000A, wmask 0x04, wdata 0x0000_0000_00AB_0000. Read back -> rdata_o=0x11223344_55AB7788. Then a write with wmask 0x00 completes and leaves the data unchanged.
4. Out of range: read addr 0x7FFF_FFF8 -> rdata_o=0, err_o=1 with finish_o. Write addr BASE+DEPTH_WORDS*8 -> err_o=1, and word DEPTH_WORDS-1 is unchanged.
5. Back-to-back and LATENCY=0 build:
   - re_i held across two consecutive requests -> finish_o at T+1 and T+3, never two consecutive high cycles.
   - Changing addr_i during BUSY (LATENCY=2) does not change the returned data.
6. Reset mid-operation: write 0xDEAD to a word, deassert rst during BUSY, then read that word -> the original value is returned and no finish_o pulse occurred for the aborted write.
